// File: rtl/wb_bus_pkg.sv
// Shared definitions for the Wishbone shared bus: FSM encoding, slave-index
// field width, default stall limit and an index-width helper.
package wb_bus_pkg;

  typedef enum logic {
    BUS_IDLE  = 1'b0,
    BUS_OWNED = 1'b1
  } bus_state_e;

  // Slave select comes from the top SLV_IDX_W address bits of the owner.
  localparam int unsigned SLV_IDX_W              = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: searches requesters starting one past the last owner
// and returns a one-hot grant for the first requester found.
//   i_req        : request vector, one bit per master
//   i_last_owner : index of the master that last released the bus
//   o_grant      : one-hot grant (all zero when nobody requests)
module wb_rr_arbiter
  import wb_bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  localparam int unsigned OW          = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [OW-1:0]          i_last_owner,
  output logic [NUM_MASTERS-1:0] o_grant
);

  // Walk last_owner+1 .. last_owner+NUM_MASTERS modulo NUM_MASTERS.
  always_comb begin : p_rr
    logic          found;
    logic [OW-1:0] k;
    o_grant = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      k = OW'((32'(i_last_owner) + i) % NUM_MASTERS);
      if (!found && i_req[k]) begin
        o_grant[k] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_shared_bus.sv
// Wishbone shared bus: one master at a time owns the bus (round-robin,
// locked while its cyc stays high) and reaches one slave selected by the top
// address nibble. Unmapped accesses get a one-cycle registered error.
// Optional stall timeout: define WB_BUS_TIMEOUT_EN to build a counter that
// errors an access stalled for TIMEOUT_CYCLES strobe cycles.
//   clk_i, rst_i                         : clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i/m_addr_i/
//   m_data_i/m_sel_i                     : per-master requests (slice k = master k)
//   m_data_o/m_ack_o/m_err_o             : per-master responses
//   s_cyc_o/s_stb_o/s_we_o/s_addr_o/
//   s_data_o/s_sel_o                     : per-slave requests
//   s_data_i/s_ack_i/s_err_i             : per-slave responses
module wb_shared_bus
  import wb_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_MASTERS-1:0]     m_cyc_i,
  input  logic [NUM_MASTERS-1:0]     m_stb_i,
  input  logic [NUM_MASTERS-1:0]     m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]  m_addr_i,
  input  logic [NUM_MASTERS*DW-1:0]  m_data_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  output logic [NUM_MASTERS*DW-1:0]  m_data_o,
  output logic [NUM_MASTERS-1:0]     m_ack_o,
  output logic [NUM_MASTERS-1:0]     m_err_o,
  output logic [NUM_SLAVES-1:0]      s_cyc_o,
  output logic [NUM_SLAVES-1:0]      s_stb_o,
  output logic [NUM_SLAVES-1:0]      s_we_o,
  output logic [NUM_SLAVES*AW-1:0]   s_addr_o,
  output logic [NUM_SLAVES*DW-1:0]   s_data_o,
  output logic [NUM_SLAVES*DW/8-1:0] s_sel_o,
  input  logic [NUM_SLAVES*DW-1:0]   s_data_i,
  input  logic [NUM_SLAVES-1:0]      s_ack_i,
  input  logic [NUM_SLAVES-1:0]      s_err_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned OW = idx_w(NUM_MASTERS);

  bus_state_e           r_state;
  logic [OW-1:0]        r_owner;
  logic [OW-1:0]        r_last_owner;
  logic                 r_umap_err;

  logic [NUM_MASTERS-1:0] w_grant;
  logic [OW-1:0]          w_grant_idx;
  logic                   w_cyc, w_stb, w_we;
  logic [AW-1:0]          w_addr;
  logic [DW-1:0]          w_wdata;
  logic [SW-1:0]          w_sel;
  logic [SLV_IDX_W-1:0]   w_sidx;
  logic                   w_mapped;
  logic                   w_active;
  logic                   w_sack, w_serr;
  logic [DW-1:0]          w_sdata;
  logic                   w_tmo_pulse;

  wb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
    .i_req       (m_cyc_i),
    .i_last_owner(r_last_owner),
    .o_grant     (w_grant)
  );

  // One-hot grant to index.
  always_comb begin
    w_grant_idx = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (w_grant[k]) w_grant_idx = OW'(k);
    end
  end

  // Owner request mux.
  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_sel   = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (r_owner == OW'(k)) begin
        w_cyc   = m_cyc_i[k];
        w_stb   = m_stb_i[k];
        w_we    = m_we_i[k];
        w_addr  = m_addr_i[k*AW +: AW];
        w_wdata = m_data_i[k*DW +: DW];
        w_sel   = m_sel_i[k*SW +: SW];
      end
    end
  end

  // Owner cyc gates everything, so an abort or reset drops strobes at once.
  assign w_active = (r_state == BUS_OWNED) && w_cyc && !rst_i;
  assign w_sidx   = w_addr[AW-1 -: SLV_IDX_W];
  assign w_mapped = 32'(w_sidx) < NUM_SLAVES;

  // Slave fan-out and response select.
  always_comb begin
    s_cyc_o  = '0;
    s_stb_o  = '0;
    s_we_o   = '0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    w_sack   = 1'b0;
    w_serr   = 1'b0;
    w_sdata  = '0;
    for (int j = 0; j < int'(NUM_SLAVES); j++) begin
      if (w_active && w_mapped && (w_sidx == SLV_IDX_W'(j))) begin
        s_cyc_o[j]           = 1'b1;
        s_stb_o[j]           = w_stb && !w_tmo_pulse;
        s_we_o[j]            = w_we;
        s_addr_o[j*AW +: AW] = w_addr;
        s_data_o[j*DW +: DW] = w_wdata;
        s_sel_o[j*SW +: SW]  = w_sel;
        w_sack               = s_ack_i[j];
        w_serr               = s_err_i[j];
        w_sdata              = s_data_i[j*DW +: DW];
      end
    end
  end

  // Responses reach the owner only; everyone else sees zeros.
  always_comb begin
    m_ack_o  = '0;
    m_err_o  = '0;
    m_data_o = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (w_active && (r_owner == OW'(k))) begin
        m_ack_o[k]           = w_sack;
        m_err_o[k]           = w_serr || r_umap_err || w_tmo_pulse;
        m_data_o[k*DW +: DW] = w_sdata;
      end
    end
  end

  // Ownership FSM: grant registers on IDLE->OWNED, release back to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= BUS_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NUM_MASTERS - 1);
    end else begin
      case (r_state)
        BUS_IDLE: begin
          if (|m_cyc_i) begin
            r_state <= BUS_OWNED;
            r_owner <= w_grant_idx;
          end
        end
        BUS_OWNED: begin
          if (!w_cyc) begin
            r_state      <= BUS_IDLE;
            r_last_owner <= r_owner;
          end
        end
        default: r_state <= BUS_IDLE;
      endcase
    end
  end

  // Unmapped strobe -> one error pulse next cycle; not re-armed by the pulse cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_active) r_umap_err <= 1'b0;
    else                    r_umap_err <= w_stb && !w_mapped && !r_umap_err;
  end

`ifdef WB_BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_err;

  // Count stalled strobe cycles; on the limit, error for one cycle and restart.
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_active) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else if (w_stb && w_mapped && !r_tmo_err && !w_sack && !w_serr) begin
      if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_tmo_cnt <= '0;
        r_tmo_err <= 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
        r_tmo_err <= 1'b0;
      end
    end else begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end
  end

  assign w_tmo_pulse = r_tmo_err;
`else
  assign w_tmo_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench for wb_shared_bus: directed scenarios plus randomized
// contention rounds checked against a transaction-level round-robin model.
module tb_wb_shared_bus;

  localparam int unsigned NM  = 2;
  localparam int unsigned NS  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst_i;
  logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_data_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*DW-1:0] m_data_o;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o, s_we_o;
  logic [NS*AW-1:0] s_addr_o;
  logic [NS*DW-1:0] s_data_o;
  logic [NS*SW-1:0] s_sel_o;
  logic [NS*DW-1:0] s_data_i;
  logic [NS-1:0]    s_ack_i, s_err_i;
  logic [NS-1:0]    stall;

  logic [31:0] mem     [NS][16];
  logic [31:0] ref_mem [NS][16];

  int n_chk  = 0;
  int n_fail = 0;
  int done_q[$];

  always #5 clk = ~clk;

  wb_shared_bus #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .DW(DW), .AW(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  assign s_err_i = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural slaves: registered ack one cycle after a strobe unless stalled.
  initial begin
    for (int j = 0; j < int'(NS); j++)
      for (int w = 0; w < 16; w++)
        mem[j][w] = 32'hA000_0000 | (32'(j) << 8) | 32'(w);
    mem[0][4] = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    for (int j = 0; j < int'(NS); j++) begin
      if (s_cyc_o[j] && s_stb_o[j] && !s_ack_i[j] && !stall[j]) begin
        if (s_we_o[j]) begin
          for (int b = 0; b < int'(SW); b++)
            if (s_sel_o[j*SW + b])
              mem[j][s_addr_o[j*AW+2 +: 4]][b*8 +: 8] <= s_data_o[j*DW + b*8 +: 8];
        end else begin
          s_data_i[j*DW +: DW] <= mem[j][s_addr_o[j*AW+2 +: 4]];
        end
        s_ack_i[j] <= 1'b1;
      end else begin
        s_ack_i[j] <= 1'b0;
      end
    end
  end

  // Monitor: completion order and single-strobe property.
  always @(negedge clk) begin
    for (int k = 0; k < int'(NM); k++)
      if (m_ack_o[k] || m_err_o[k]) done_q.push_back(k);
    if (s_stb_o != '0) chk("stb_onehot", 64'($countones(s_stb_o)), 64'(1));
  end

  // One access by master m; entered and left at posedge+1.
  task automatic master_txn(input int m, input logic [31:0] addr, input logic we,
                            input logic [31:0] wd, input logic [3:0] sel,
                            output logic [31:0] rd, output logic er);
    logic done;
    int   n;
    m_cyc_i[m] = 1'b1;
    m_stb_i[m] = 1'b1;
    m_we_i[m]  = we;
    m_addr_i[m*AW +: AW] = addr;
    m_data_i[m*DW +: DW] = wd;
    m_sel_i[m*SW +: SW]  = sel;
    rd = '0; er = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (m_ack_o[m] || m_err_o[m]) begin
        done = 1'b1;
        rd   = m_data_o[m*DW +: DW];
        er   = m_err_o[m];
      end
      n++;
    end
    chk("txn_done", 64'(done), 64'(1));
    @(posedge clk); #1;
    m_cyc_i[m] = 1'b0;
    m_stb_i[m] = 1'b0;
    m_we_i[m]  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] ad [NM];
  logic        we_a [NM];
  logic [31:0] wd [NM];
  logic [3:0]  sl [NM];
  logic [31:0] rd_a [NM];
  logic        er_a [NM];
  logic [31:0] rd_b [NM];
  logic        er_b [NM];

  initial begin
    int errc, stbc, first, cnt, mdl_last;
    int exp_order[$];
    logic dropped;
    logic [NM-1:0] mask;
    logic [3:0] sidx;
    logic [31:0] exp_rd;

    for (int j = 0; j < int'(NS); j++)
      for (int w = 0; w < 16; w++)
        ref_mem[j][w] = 32'hA000_0000 | (32'(j) << 8) | 32'(w);
    ref_mem[0][4] = 32'hDEAD_BEEF;

    rst_i = 1'b1; stall = '0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_addr_i = '0; m_data_i = '0; m_sel_i = '0;
    idle(3);
    rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'(0));
    chk("rst_s_stb", 64'(s_stb_o), 64'(0));
    chk("rst_m_ack", 64'(m_ack_o), 64'(0));
    chk("rst_m_err", 64'(m_err_o), 64'(0));
    chk("rst_m_data", 64'(m_data_o), 64'(0));
    @(posedge clk); #1;

    // Master 0 read from slave 0 with one-cycle grant latency
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_we_i[0] = 1'b0;
    m_addr_i[0 +: AW] = 32'h0000_0010; m_sel_i[0 +: SW] = 4'hF;
    @(negedge clk); chk("lat_req_cycle", 64'(s_stb_o), 64'(0));
    @(negedge clk); chk("rd_stb_slave0", 64'(s_stb_o), 64'(4'b0001));
    chk("rd_no_early_ack", 64'(m_ack_o), 64'(0));
    @(negedge clk); chk("rd_ack", 64'(m_ack_o), 64'(2'b01));
    chk("rd_data", 64'(m_data_o[0 +: DW]), 64'(32'hDEAD_BEEF));
    chk("rd_m1_data_zero", 64'(m_data_o[DW +: DW]), 64'(0));
    @(posedge clk); #1;
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    idle(2);

    // Unmapped write by master 1
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b1;
    m_addr_i[AW +: AW] = 32'h5000_0000; m_data_i[DW +: DW] = 32'h1234_5678;
    m_sel_i[SW +: SW] = 4'hF;
    errc = 0; stbc = 0; first = -1; dropped = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (s_stb_o != '0) stbc++;
      if (m_err_o[1]) begin errc++; if (first < 0) first = c; end
      @(posedge clk); #1;
      if (errc != 0 && !dropped) begin
        m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0; m_we_i[1] = 1'b0; dropped = 1'b1;
      end
    end
    chk("umap_err_count", 64'(errc), 64'(1));
    chk("umap_err_cycle", 64'(first), 64'(2));
    chk("umap_no_stb", 64'(stbc), 64'(0));

    // Both masters request continuously: grants alternate
    done_q.delete();
    fork
      begin
        master_txn(0, 32'h1000_0008, 1'b0, 32'h0, 4'hF, rd_a[0], er_a[0]);
        master_txn(0, 32'h1000_0008, 1'b0, 32'h0, 4'hF, rd_b[0], er_b[0]);
      end
      begin
        master_txn(1, 32'h2000_000C, 1'b0, 32'h0, 4'hF, rd_a[1], er_a[1]);
        master_txn(1, 32'h2000_000C, 1'b0, 32'h0, 4'hF, rd_b[1], er_b[1]);
      end
    join
    chk("rr_len", 64'(done_q.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      if (i < done_q.size()) chk("rr_order", 64'(done_q[i]), 64'(i % 2));
    chk("rr_rd_m0", 64'(rd_b[0]), 64'(ref_mem[1][2]));
    chk("rr_rd_m1", 64'(rd_a[1]), 64'(ref_mem[2][3]));

    // Owner aborts before ack while master 1 waits
    stall[1] = 1'b1;
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = '0; m_sel_i = '1;
    m_addr_i[0 +: AW] = 32'h1000_0000; m_addr_i[AW +: AW] = 32'h3000_0000;
    @(negedge clk);
    @(negedge clk); chk("abort_pre_stb", 64'(s_stb_o), 64'(4'b0010));
    @(posedge clk); #1;
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    @(negedge clk); chk("abort_same_cycle", 64'(s_stb_o), 64'(0));
    @(negedge clk); chk("abort_idle_gap", 64'(s_stb_o), 64'(0));
    @(negedge clk); chk("abort_m1_grant", 64'(s_stb_o), 64'(4'b1000));
    @(negedge clk); chk("abort_m1_ack", 64'(m_ack_o), 64'(2'b10));
    chk("abort_m1_data", 64'(m_data_o[DW +: DW]), 64'(ref_mem[3][0]));
    @(posedge clk); #1;
    m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
    stall[1] = 1'b0;
    idle(2);

    // Reset mid-access; first grant afterwards goes to master 0
    master_txn(0, 32'h0000_0004, 1'b0, 32'h0, 4'hF, rd_a[0], er_a[0]);
    chk("pre_rst_rd", 64'(rd_a[0]), 64'(ref_mem[0][1]));
    stall[1] = 1'b1;
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_addr_i[AW +: AW] = 32'h1000_0004;
    @(negedge clk);
    @(negedge clk); chk("rst_mid_stb", 64'(s_stb_o), 64'(4'b0010));
    @(posedge clk); #1;
    rst_i = 1'b1;
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_addr_i[0 +: AW] = 32'h0000_0000;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_s_stb", 64'(s_stb_o), 64'(0));
    chk("rst_mid_s_cyc", 64'(s_cyc_o), 64'(0));
    chk("rst_mid_m_ack", 64'(m_ack_o), 64'(0));
    @(negedge clk); chk("post_rst_grant", 64'(s_stb_o), 64'(4'b0001));
    @(posedge clk); #1;
    m_cyc_i = '0; m_stb_i = '0;
    stall[1] = 1'b0;
    idle(3);

    // Stalled slave 2: timeout error only when the counter is built
    stall[2] = 1'b1;
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_addr_i[0 +: AW] = 32'h2000_0000;
    cnt = 0;
    while (s_stb_o[2] !== 1'b1 && cnt < 10) begin @(negedge clk); cnt++; end
    chk("tmo_stb_start", 64'(s_stb_o[2]), 64'(1));
`ifdef WB_BUS_TIMEOUT_EN
    cnt = 0;
    while (!m_err_o[0] && cnt < 50) begin @(negedge clk); cnt++; end
    chk("tmo_err_delay", 64'(cnt), 64'(TMO));
    chk("tmo_stb_dropped", 64'(s_stb_o[2]), 64'(0));
    @(negedge clk); chk("tmo_err_one_cycle", 64'(m_err_o[0]), 64'(0));
`else
    errc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_err_o != '0) errc++;
    end
    chk("no_tmo_err", 64'(errc), 64'(0));
    chk("no_tmo_stb_held", 64'(s_stb_o[2]), 64'(1));
`endif
    @(posedge clk); #1;
    m_cyc_i = '0; m_stb_i = '0;
    stall[2] = 1'b0;
    idle(3);

    // Randomized contention rounds against a transaction-level model
    mdl_last = 0;
    for (int r = 0; r < 25; r++) begin
      mask = NM'($urandom_range(1, 3));
      for (int k = 0; k < int'(NM); k++) begin
        sidx    = 4'($urandom_range(0, 5));
        ad[k]   = {sidx, 22'b0, 4'($urandom_range(0, 15)), 2'b00};
        we_a[k] = 1'($urandom_range(0, 1));
        wd[k]   = $urandom;
        sl[k]   = we_a[k] ? 4'($urandom_range(1, 15)) : 4'hF;
      end
      exp_order.delete();
      for (int i = 1; i <= int'(NM); i++)
        if (mask[(mdl_last + i) % NM]) exp_order.push_back((mdl_last + i) % NM);
      done_q.delete();
      fork
        begin if (mask[0]) master_txn(0, ad[0], we_a[0], wd[0], sl[0], rd_a[0], er_a[0]); end
        begin if (mask[1]) master_txn(1, ad[1], we_a[1], wd[1], sl[1], rd_a[1], er_a[1]); end
      join
      chk("rnd_order_len", 64'(done_q.size()), 64'(exp_order.size()));
      foreach (exp_order[i]) begin
        int k;
        k = exp_order[i];
        if (i < done_q.size()) chk("rnd_order", 64'(done_q[i]), 64'(k));
        sidx = ad[k][31:28];
        if (32'(sidx) >= NS) begin
          chk("rnd_umap_err", 64'(er_a[k]), 64'(1));
        end else begin
          chk("rnd_err", 64'(er_a[k]), 64'(0));
          if (we_a[k]) begin
            for (int b = 0; b < 4; b++)
              if (sl[k][b]) ref_mem[sidx][ad[k][5:2]][b*8 +: 8] = wd[k][b*8 +: 8];
          end else begin
            exp_rd = ref_mem[sidx][ad[k][5:2]];
            chk("rnd_rdata", 64'(rd_a[k]), 64'(exp_rd));
          end
        end
      end
      if (exp_order.size() > 0) mdl_last = exp_order[exp_order.size()-1];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_shared_bus.md
WB_SHARED_BUS -- requirements
Module: wb_shared_bus

Interface
REQ-001 Parameters SHALL be: NUM_MASTERS, default 2, range 1..4, count of Wishbone masters.
REQ-002 NUM_SLAVES, default 4, range 1..8, count of Wishbone slaves.
REQ-003 DW, default 32, data width (multiple of 8); AW, default 32, address width.
REQ-004 TIMEOUT_CYCLES, default 255, stall limit used when WB_BUS_TIMEOUT_EN is defined.
REQ-005 clk_i  in  1  single bus clock; all logic on the rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS each  per-master Wishbone controls.
REQ-008 m_addr_i  in  NUM_MASTERS*AW, m_data_i  in  NUM_MASTERS*DW, m_sel_i  in  NUM_MASTERS*DW/8; master k occupies slice k.
REQ-009 m_data_o  out  NUM_MASTERS*DW; m_ack_o, m_err_o  out  NUM_MASTERS  per-master responses.
REQ-010 s_cyc_o, s_stb_o, s_we_o  out  NUM_SLAVES; s_addr_o  out  NUM_SLAVES*AW; s_data_o  out  NUM_SLAVES*DW; s_sel_o  out  NUM_SLAVES*DW/8.
REQ-011 s_data_i  in  NUM_SLAVES*DW; s_ack_i, s_err_i  in  NUM_SLAVES.

Function
REQ-012 The block SHALL be a shared bus: at most one master owns the bus; it SHALL reach exactly one slave per access.
REQ-013 FSM states SHALL be IDLE and OWNED; IDLE->OWNED when any m_cyc_i=1; OWNED->IDLE on the cycle the owner deasserts m_cyc_i.
REQ-014 Arbitration SHALL be round-robin: the search starts at last_owner+1 modulo NUM_MASTERS; the first requester wins; the grant registers at the IDLE->OWNED edge.
REQ-015 Grant latency SHALL be 1 cycle: a request in cycle n is first forwarded to the slave in cycle n+1.
REQ-016 The owner SHALL keep the bus while m_cyc_i stays high (locked bursts); on release last_owner SHALL update to the owner.
REQ-017 The slave index SHALL be m_addr_i[AW-1:AW-4] of the owner; an index >= NUM_SLAVES is unmapped.
REQ-018 For a mapped slave, owner addr, data, sel and we SHALL route combinationally to that slave; s_cyc_o/s_stb_o SHALL be 1 only on the selected slave.
REQ-019 Slave ack, err and data SHALL return combinationally to the owner only; non-owners SHALL see ack=err=0 and data=0.
REQ-020 An unmapped access SHALL assert no slave strobe; m_err_o of the owner SHALL pulse for exactly 1 cycle, registered, 1 cycle after the stb cycle.
REQ-021 A master that drops m_cyc_i mid-access SHALL abort it; the slave strobe SHALL fall in the same cycle; any pending error pulse SHALL be cancelled.
REQ-022 A request arriving in the release cycle SHALL be arbitrated from IDLE on the next cycle; there is no back-to-back handover.

Reset
REQ-023 While rst_i=1 the FSM SHALL go to IDLE, no owner, last_owner=NUM_MASTERS-1 (master 0 wins first), error/timeout state cleared.
REQ-024 Reset SHALL force all s_cyc_o, s_stb_o, m_ack_o and m_err_o to 0, including in the middle of an access.

Configuration
REQ-025 With WB_BUS_TIMEOUT_EN defined, a counter SHALL count owner cycles with stb=1 and no ack/err; at TIMEOUT_CYCLES it SHALL pulse m_err_o for 1 cycle, drop the slave strobe that cycle, and clear.
REQ-026 Without WB_BUS_TIMEOUT_EN, no counter SHALL be built; a stalled slave holds the bus indefinitely.

Structure
REQ-027 The shared package wb_bus_pkg SHALL hold the FSM state encoding, the slave-index field width (4) and the default TIMEOUT_CYCLES.
REQ-028 The round-robin arbiter SHALL be the sub-module wb_rr_arbiter (request vector, last_owner in; one-hot grant out).

Verification
REQ-029 Master 0 reads addr 0x0000_0010, slave 0 acks with 0xDEADBEEF -> m_data_o slice 0 = 0xDEADBEEF with m_ack_o[0]=1; only s_stb_o[0] is high.
REQ-030 Masters 0 and 1 request continuously after reset -> grants alternate 0,1,0,1 across four released accesses.
REQ-031 Master 1 writes addr 0x5000_0000 with NUM_SLAVES=4 -> no s_stb_o; m_err_o[1]=1 for exactly one cycle.
REQ-032 Slave 2 never acks, WB_BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 -> m_err_o pulses 8 stall cycles after stb; without the macro there is no pulse after 100 cycles.
REQ-033 rst_i asserted mid-access with slave 1 strobed -> all strobes are 0 the next cycle; the first post-reset grant goes to master 0.
REQ-034 The owner drops m_cyc_i before ack while master 1 waits -> the slave strobe falls in the same cycle; master 1 is granted the cycle after IDLE.
